// File: rtl/spike_pkg.sv
// Shared constants, FSM state encoding and saturation helper for the spike packetizer.
// Optional rate monitor in the top module is enabled with macro SPK_RATE_EN.
package spike_pkg;

    localparam int TS_W_DEF       = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [7:0] DROP_SAT = 8'hFF;

    localparam logic [0:0] ST_ARMED   = 1'b0;
    localparam logic [0:0] ST_REFRACT = 1'b1;

    typedef enum logic [0:0] {
        ARMED   = ST_ARMED,
        REFRACT = ST_REFRACT
    } spike_state_e;

    // Add one to an 8-bit counter without rolling over past DROP_SAT.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
        if (inc && (v != DROP_SAT)) begin
            return v + 8'd1;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// Small timestamp FIFO: synchronous push/pop, head served from the register bank,
// and a simultaneous push+pop is accepted even when full.
module spike_fifo
    import spike_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_full
);

    localparam int            AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW - 1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("spike_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == {(AW + 1){1'b0}});
    // A pop in the same cycle frees the slot the push needs.
    assign w_push_ok = i_push & (~w_full | i_pop);
    assign w_pop_ok  = i_pop & ~w_empty;

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = ~w_empty;
    assign o_full  = w_full;

    // Storage write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spike_packetizer.sv
// Timestamps rising spike edges, enforces a refractory period and queues events.
// Define SPK_RATE_EN to add the windowed spike-rate outputs rate_cnt/rate_valid.
module spike_packetizer
    import spike_pkg::*;
#(
    parameter int TS_W          = TS_W_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int RATE_WIN_LOG2 = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            spike_in,
    input  logic [7:0]      refractory_in,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [TS_W-1:0] evt_ts,
    output logic            overflow,
    output logic [7:0]      drop_cnt
`ifdef SPK_RATE_EN
    ,
    output logic [7:0]      rate_cnt,
    output logic            rate_valid
`endif
);

    localparam logic [TS_W-1:0] TS_ONE = {{(TS_W - 1){1'b0}}, 1'b1};

    if ((RATE_WIN_LOG2 < 1) || (RATE_WIN_LOG2 > 30)) begin : g_bad_win
        $error("spike_packetizer: RATE_WIN_LOG2 out of range");
    end

    logic [TS_W-1:0] r_ts;
    logic            r_spike_d;
    spike_state_e    r_state;
    logic [7:0]      r_rcnt;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;

    spike_state_e    w_state_nxt;
    logic [7:0]      w_rcnt_nxt;
    logic            w_edge;
    logic            w_accept;
    logic            w_pop;
    logic            w_full;
    logic            w_drop;

    assign w_edge   = spike_in & ~r_spike_d;
    assign w_accept = (r_state == ARMED) & w_edge;
    assign w_pop    = evt_valid & evt_ready;
    assign w_drop   = w_accept & w_full & ~w_pop;

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

    // Free-running timestamp, edge-detect history and FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts      <= {TS_W{1'b0}};
            r_spike_d <= 1'b0;
            r_state   <= ARMED;
            r_rcnt    <= 8'd0;
        end else begin
            r_ts      <= r_ts + TS_ONE;
            r_spike_d <= spike_in;
            r_state   <= w_state_nxt;
            r_rcnt    <= w_rcnt_nxt;
        end
    end

    // Refractory FSM: a spike with refractory R blocks the next R cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        case (r_state)
            ARMED: begin
                if (w_edge) begin
                    w_rcnt_nxt  = refractory_in;
                    w_state_nxt = (refractory_in != 8'd0) ? REFRACT : ARMED;
                end else begin
                    w_rcnt_nxt  = r_rcnt;
                    w_state_nxt = ARMED;
                end
            end
            REFRACT: begin
                w_rcnt_nxt = r_rcnt - 8'd1;
                if (r_rcnt <= 8'd1) begin
                    w_state_nxt = ARMED;
                end else begin
                    w_state_nxt = REFRACT;
                end
            end
            default: begin
                w_rcnt_nxt  = 8'd0;
                w_state_nxt = ARMED;
            end
        endcase
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_overflow <= r_overflow | w_drop;
            r_drop_cnt <= sat_inc8(r_drop_cnt, w_drop);
        end
    end

    spike_fifo #(
        .W     (TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_data  (r_ts),
        .o_data  (evt_ts),
        .o_valid (evt_valid),
        .o_full  (w_full)
    );

`ifdef SPK_RATE_EN
    localparam logic [RATE_WIN_LOG2-1:0] WIN_ONE = {{(RATE_WIN_LOG2 - 1){1'b0}}, 1'b1};

    logic [RATE_WIN_LOG2-1:0] r_win;
    logic [7:0]               r_acc;
    logic [7:0]               r_rate_cnt;
    logic                     r_rate_valid;
    logic                     w_win_end;

    assign w_win_end  = &r_win;
    assign rate_cnt   = r_rate_cnt;
    assign rate_valid = r_rate_valid;

    // Window accumulator; a spike in the final window cycle still counts there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win        <= {RATE_WIN_LOG2{1'b0}};
            r_acc        <= 8'd0;
            r_rate_cnt   <= 8'd0;
            r_rate_valid <= 1'b0;
        end else begin
            r_win <= r_win + WIN_ONE;
            if (w_win_end) begin
                r_rate_cnt   <= sat_inc8(r_acc, w_accept);
                r_acc        <= 8'd0;
                r_rate_valid <= 1'b1;
            end else begin
                r_acc        <= sat_inc8(r_acc, w_accept);
                r_rate_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spike_packetizer.sv
// Scoreboard bench for spike_packetizer; rate checks are built when SPK_RATE_EN is defined.
module tb_spike_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spike_in = 1'b0;
    logic [7:0]  refractory_in = 8'd0;
    logic        evt_ready = 1'b0;
    logic        evt_valid;
    logic [15:0] evt_ts;
    logic        overflow;
    logic [7:0]  drop_cnt;
`ifdef SPK_RATE_EN
    logic [7:0]  rate_cnt;
    logic        rate_valid;
`endif

    int          errors = 0;
    int          checks = 0;
    int          cyc;
    logic [15:0] exp_q [$];

    spike_packetizer #(
        .TS_W          (16),
        .FIFO_DEPTH    (4),
        .RATE_WIN_LOG2 (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spike_in      (spike_in),
        .refractory_in (refractory_in),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_ts        (evt_ts),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
`ifdef SPK_RATE_EN
        ,
        .rate_cnt      (rate_cnt),
        .rate_valid    (rate_valid)
`endif
    );

    always #5 clk = ~clk;

    // Cycles since reset release; equals the DUT timestamp between edges.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_ts(input int n);
        if (cyc > n) begin
            checks++;
            errors++;
            $display("FAIL sched: target %0d already passed at %0d", n, cyc);
        end
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single-cycle spike pulse at timestamp t; queue t if it must be emitted.
    task automatic edge_at(input int t, input logic [7:0] refr, input bit expect_evt);
        logic [15:0] e;
        wait_ts(t);
        refractory_in = refr;
        spike_in      = 1'b1;
        e = 16'(t);
        if (expect_evt) exp_q.push_back(e);
        wait_ts(t + 1);
        spike_in = 1'b0;
    endtask

    // Monitor: every accepted output beat must match the queue head.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_evt: got ts %0h expected none", evt_ts);
            end else begin
                chk("evt_ts", {16'd0, evt_ts}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        chk("rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("rst_ts", {16'd0, evt_ts}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
`ifdef SPK_RATE_EN
        chk("rst_rate_cnt", {24'd0, rate_cnt}, 32'd0);
        chk("rst_rate_valid", {31'd0, rate_valid}, 32'd0);
`endif
        #1 rst = 1'b0;
        evt_ready = 1'b1;

        // First edge at ts=5, one-cycle latency to evt_valid
        wait_ts(5);
        refractory_in = 8'd3;
        spike_in = 1'b1;
        exp_q.push_back(16'd5);
        wait_ts(6);
        spike_in = 1'b0;
        chk("lat_valid", {31'd0, evt_valid}, 32'd1);
        chk("lat_ts", {16'd0, evt_ts}, 32'd5);
        wait_ts(7);
        chk("pulse_end", {31'd0, evt_valid}, 32'd0);

        // Refractory: edge at 12 ignored, 14 accepted
        edge_at(10, 8'd3, 1'b1);
        edge_at(12, 8'd3, 1'b0);
        edge_at(14, 8'd3, 1'b1);
        wait_ts(18);
        chk("refr_drop", {24'd0, drop_cnt}, 32'd0);
        chk("refr_ovf", {31'd0, overflow}, 32'd0);
        chk("refr_qempty", exp_q.size(), 32'd0);

        // Overflow: six edges, four held, two dropped
        evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) edge_at(20 + 2 * i, 8'd0, i < 4);
        wait_ts(32);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_drop", {24'd0, drop_cnt}, 32'd2);
        chk("ovf_valid", {31'd0, evt_valid}, 32'd1);
        chk("ovf_head", {16'd0, evt_ts}, 32'd20);
        wait_ts(35);
        chk("hold_head", {16'd0, evt_ts}, 32'd20);
        chk("hold_valid", {31'd0, evt_valid}, 32'd1);

        // Full FIFO with pop and push in the same cycle
        wait_ts(40);
        evt_ready = 1'b1;
        refractory_in = 8'd0;
        spike_in = 1'b1;
        exp_q.push_back(16'd40);
        wait_ts(41);
        evt_ready = 1'b0;
        spike_in = 1'b0;
        chk("pp_drop", {24'd0, drop_cnt}, 32'd2);
        chk("pp_head", {16'd0, evt_ts}, 32'd22);
        edge_at(42, 8'd0, 1'b0);
        wait_ts(44);
        chk("still_full_drop", {24'd0, drop_cnt}, 32'd3);
        evt_ready = 1'b1;
        wait_ts(52);
        chk("drain_valid", {31'd0, evt_valid}, 32'd0);
        chk("drain_qempty", exp_q.size(), 32'd0);

        // Reset during refractory with two events queued
        evt_ready = 1'b0;
        edge_at(60, 8'd0, 1'b1);
        edge_at(62, 8'd9, 1'b1);
        wait_ts(65);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        chk("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        evt_ready = 1'b1;
        edge_at(3, 8'd9, 1'b1);
        chk("post_rst_valid", {31'd0, evt_valid}, 32'd1);
        chk("post_rst_ts", {16'd0, evt_ts}, 32'd3);
        wait_ts(8);
        chk("post_rst_qempty", exp_q.size(), 32'd0);

        // Timestamp wrap
        edge_at(65535, 8'd0, 1'b1);
        chk("wrap_hi", {16'd0, evt_ts}, 32'h0000FFFF);
        edge_at(65537, 8'd0, 1'b1);
        chk("wrap_lo", {16'd0, evt_ts}, 32'd1);
        wait_ts(65540);
        chk("wrap_qempty", exp_q.size(), 32'd0);

`ifdef SPK_RATE_EN
        // Rate window of 16 cycles with three accepted spikes
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        edge_at(2, 8'd0, 1'b1);
        edge_at(4, 8'd0, 1'b1);
        edge_at(6, 8'd0, 1'b1);
        wait_ts(15);
        chk("rate_pre", {31'd0, rate_valid}, 32'd0);
        wait_ts(16);
        chk("rate_pulse", {31'd0, rate_valid}, 32'd1);
        chk("rate_cnt", {24'd0, rate_cnt}, 32'd3);
        wait_ts(17);
        chk("rate_post", {31'd0, rate_valid}, 32'd0);
`endif

        chk("final_qempty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_packetizer.md
SPIKE_PACKETIZER -- requirements
Module: spike_packetizer

Interface
REQ-001 SHALL have parameter TS_W, default 16, timestamp width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries, power of two and at least 2.
REQ-003 SHALL have parameter RATE_WIN_LOG2, default 10, log2 of the rate window in cycles; used only with SPK_RATE_EN.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 spike_in  in  1  level spike flag from the upstream detector.
REQ-007 refractory_in  in  8  refractory length in cycles, sampled on each accepted spike.
REQ-008 evt_valid  out  1  FIFO head holds an event.
REQ-009 evt_ready  in  1  downstream accepts the head.
REQ-010 evt_ts  out  TS_W  timestamp of the head event.
REQ-011 overflow  out  1  sticky flag; an event was dropped.
REQ-012 drop_cnt  out  8  saturating count of dropped events.
REQ-013 rate_cnt  out  8  spikes accepted in the last window (SPK_RATE_EN only).
REQ-014 rate_valid  out  1  one-cycle pulse when rate_cnt updates (SPK_RATE_EN only).

Function
REQ-015 SHALL run a free-running TS_W-bit counter ts that increments every cycle and wraps from all-ones to 0.
REQ-016 SHALL register spike_in and detect a rising edge: spike_in=1 with the previous sample at 0.
REQ-017 FSM SHALL have two states: ARMED and REFRACT.
REQ-018 ARMED with a rising edge: SHALL accept the spike, push ts of the edge cycle, and load rcnt=refractory_in.
- Next state is REFRACT when refractory_in≠0, otherwise ARMED.
REQ-019 REFRACT: SHALL ignore rising edges (no push, no drop count) and decrement rcnt each cycle.
- Returns to ARMED in the cycle after rcnt reaches 1.
- With refractory_in=R, the next spike can be accepted R+1 cycles after the previous one.
REQ-020 evt_valid SHALL assert the cycle after the push into an empty FIFO (latency 1).
REQ-021 A pop SHALL occur on a cycle with evt_valid and evt_ready both high.
- evt_ts and evt_valid stay stable while evt_valid=1 and evt_ready=0.
REQ-022 FIFO SHALL be first-in first-out.
REQ-023 Push while full with no pop: SHALL drop the new event, set overflow, and increment drop_cnt, saturating at 255.
REQ-024 Push and pop in the same cycle while full: SHALL accept both, leaving the occupancy unchanged and recording no drop.
REQ-025 Pop on empty SHALL be impossible, because evt_valid=0.
REQ-026 A push and pop in the same cycle on a FIFO holding one entry SHALL leave exactly that one new entry.

Reset
REQ-027 rst SHALL clear all of the following asynchronously:
- ts=0, state=ARMED, rcnt=0, previous spike sample=0.
- FIFO empty, evt_valid=0, evt_ts=0, overflow=0, drop_cnt=0, rate_cnt=0, rate_valid=0.
REQ-028 rst asserted mid-refractory or with a non-empty FIFO SHALL discard all pending events and state.
- The first rising edge after release is accepted.

Configuration
REQ-029 Macro SPK_RATE_EN defined: SHALL count accepted spikes over consecutive 2^RATE_WIN_LOG2-cycle windows, saturating at 255.
- At each window end, rate_cnt is loaded and rate_valid pulses for one cycle.
- A spike accepted in the last window cycle counts in that window.
REQ-030 SPK_RATE_EN undefined: rate_cnt and rate_valid SHALL be absent from the port list, with no rate logic synthesised.

Structure
REQ-031 Package spike_pkg SHALL hold:
- the TS_W and FIFO_DEPTH defaults;
- the FSM state enum {ARMED, REFRACT};
- the drop_cnt saturation constant.
REQ-032 FIFO SHALL be sub-module spike_fifo.
- Synchronous push/pop, registered output, full/empty flags, same-cycle push/pop when full permitted.

Verification
REQ-033 Reset release, spike_in 0→1 at ts=5, refractory_in=3, evt_ready=1 -> evt_valid pulses one cycle later with evt_ts=5.
REQ-034 refractory_in=3, edges at ts=10, 12, 14 -> only ts=10 and ts=14 are emitted; no drop counted.
REQ-035 evt_ready=0, refractory_in=0, six edges spaced 2 cycles apart -> 4 events held, overflow=1, drop_cnt=2; draining yields the first four timestamps in order.
REQ-036 FIFO full with evt_ready=1 and a new edge in the same cycle -> the event is accepted, drop_cnt is unchanged, and occupancy stays 4.
REQ-037 Edge at ts=16'hFFFF -> evt_ts=16'hFFFF; the next edge 2 cycles later -> evt_ts=1 (wrap).
REQ-038 SPK_RATE_EN, RATE_WIN_LOG2=4, 3 accepted spikes in the first window -> rate_valid pulses at cycle 16 with rate_cnt=3.
REQ-039 rst asserted during REFRACT with 2 events queued -> evt_valid=0 immediately, and the first edge after release is emitted.
